router_1xn: RTL and testbench
=============================

Name: router_1xn

Overview:
- Parametrised 1-to-N packet router; next generation of the fixed 1x3 byte router.
- Accepts byte-serial packets on one input and steers each packet to one of NUM_PORTS output FIFOs using the header address field.
- Checks parity and length, applies backpressure via busy, and flushes output queues that go unread.
- Sits between the packet source and NUM_PORTS independent readers.

Parameters:
- DATA_W, 8, byte width. Header = {len[DATA_W-ADDR_W-1:0], addr[ADDR_W-1:0]}.
- NUM_PORTS, 3, number of output channels (2..8).
- ADDR_W, $clog2(NUM_PORTS), derived; not overridden.
- DEPTH, 16, words per output FIFO (power of 2, ≥4).
- TIMEOUT, 30, cycles a non-empty, unread FIFO may wait before soft flush.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- data_in  in  DATA_W  header / payload / parity byte
- pkt_valid  in  1  high for header and payload; low on parity byte
- read_enb  in  NUM_PORTS  per-channel read request
- data_out  out  NUM_PORTS*DATA_W  channel k at [k*DATA_W +: DATA_W]
- valid_out  out  NUM_PORTS  channel FIFO non-empty
- busy  out  1  input byte not accepted this cycle
- error  out  1  one-cycle pulse: parity or length mismatch
- drop  out  1  one-cycle pulse: packet discarded (bad address)

Behaviour:
- Reset: FSM to IDLE; all FIFOs empty; data_out=0; valid_out=0; busy=0; error=0; drop=0; parity and length counters cleared. Reset mid-packet abandons the packet; the source restarts from the header.
- Acceptance: a byte is accepted on a rising edge iff the FSM expects input and busy=0. busy is combinational from state and the selected FIFO's full flag.
- FSM states:
  - IDLE: pkt_valid=1 → header.
    - addr<NUM_PORTS and dest not full: write header; dest latched; parity=header; cnt=0 → LOAD.
    - dest full: busy=1, hold in IDLE.
    - addr≥NUM_PORTS: → DROP.
  - LOAD: pkt_valid=1 → write payload, parity^=byte, cnt++. pkt_valid=0 → write parity byte → CHECK. Dest full → busy=1, byte not consumed.
  - CHECK (1 cycle): busy=1. error=1 next cycle if computed parity ≠ received parity or cnt ≠ len. → IDLE.
  - DROP: consume bytes without writes, busy=0, until the pkt_valid=0 byte; drop pulses the cycle after → IDLE.
- FIFO: each FIFO stores the whole packet (header, payload, parity).
  - Full and read in the same cycle: the write is accepted (busy=0).
  - Empty: read_enb ignored; data_out holds its value.
- Read latency: read_enb[k] && valid_out[k] at edge t puts the head word on data_out[k] at t+1.
  - valid_out[k] falls the cycle after the last word is read.
- Soft flush: per-channel counter increments while valid_out[k]=1 and read_enb[k]=0; reset to 0 on any read.
  - At TIMEOUT the FIFO empties in one cycle.
  - Flushing the FIFO currently being loaded forces the FSM into DROP for the rest of that packet.
- Pointers wrap modulo DEPTH. Full and empty are distinguished with an extra pointer bit.

Optional Feature:
- ROUTER_1XN_DROP_BAD_EN defined:
  - Each FIFO keeps a committed write pointer, advanced only at CHECK.
  - On parity/length error the write pointer rolls back to it, so the packet never becomes visible: valid_out stays low for that packet and error and drop both pulse.
  - Readers only see complete packets: valid_out asserts after CHECK.
- Undefined: bytes are visible as written and error is flag-only.

Decomposition:
- Package router_1xn_pkg holds the FSM state enum (IDLE, LOAD, CHECK, DROP), header field-slice constants, and the width helper functions.
- One sub-module, router_1xn_fifo: DEPTH×DATA_W synchronous FIFO with soft-flush counter and optional commit/rollback. Instantiated NUM_PORTS times by generate.

Test Plan:
- Good packet, addr=0, len=14, read_enb[0] held high → 16 bytes out in order; valid_out[0] drops after the parity byte; error=0.
- len=16, addr=1, reader idle until FIFO full (DEPTH=16) → busy=1 on the 17th byte; assert read_enb[1] → busy drops the same cycle and the packet completes intact.
- Bad parity, addr=2, len=12 → error pulses exactly 1 cycle after the parity byte.
  - Feature undefined: 14 words readable.
  - Feature defined: valid_out[2] never asserts.
- Header addr=3 with NUM_PORTS=3 → busy stays 0; drop pulses after the parity byte; no FIFO changes.
- len=14 to port 0, no reads for 30 cycles → FIFO 0 flushed at cycle 30, valid_out[0]=0; a subsequent packet is routed normally.
- Reset asserted mid-payload → all outputs return to reset values next cycle; a following len=5 packet to port 1 is delivered correctly.

Source files
------------

// File: rtl/router_1xn_pkg.sv
// Shared types and helpers for the 1-to-N packet router.
// Optional build macro ROUTER_1XN_DROP_BAD_EN is consumed by the router and its FIFOs.
package router_1xn_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, CHECK, DROP} state_t;

   // Header layout is {len, addr}; addr sits at the bottom of the byte.
   localparam int HDR_ADDR_LSB = 0;

   function automatic int addr_w(input int ports);
      return (ports > 1) ? $clog2(ports) : 1;
   endfunction

   function automatic int len_w(input int data_w, input int ports);
      return data_w - addr_w(ports);
   endfunction

   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/router_1xn_if.sv
// Packet input, per-channel read side and status flags of the router.
interface router_1xn_if #(
   parameter int DATA_W    = 8,
   parameter int NUM_PORTS = 3
);
   logic [DATA_W-1:0]           data_in;
   logic                        pkt_valid;
   logic [NUM_PORTS-1:0]        read_enb;
   logic [NUM_PORTS*DATA_W-1:0] data_out;
   logic [NUM_PORTS-1:0]        valid_out;
   logic                        busy;
   logic                        error;
   logic                        drop;

   modport master (
      output data_in, pkt_valid, read_enb,
      input  data_out, valid_out, busy, error, drop
   );

   modport slave (
      input  data_in, pkt_valid, read_enb,
      output data_out, valid_out, busy, error, drop
   );
endinterface

// File: rtl/router_1xn_fifo.sv
// Per-channel output FIFO with soft-flush timer; ROUTER_1XN_DROP_BAD_EN adds
// a committed write pointer so only checked packets become visible.
module router_1xn_fifo
   import router_1xn_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int DEPTH   = 16,
   parameter int TIMEOUT = 30
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              wr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              rd,
   input  logic              commit,
   input  logic              rollback,
   output logic [DATA_W-1:0] rdata,
   output logic              valid,
   output logic              ready,
   output logic              flush
);
   localparam int PW = ptr_w(DEPTH);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW:0]       wr_ptr, rd_ptr, vis_ptr, wr_nx;
   logic [TW-1:0]     idle_cnt;
   logic              full, rd_fire, stale;

   assign wr_nx   = wr_ptr + {{PW{1'b0}}, wr};
   assign full    = (wr_ptr ^ rd_ptr) == {1'b1, {PW{1'b0}}};
   assign valid   = vis_ptr != rd_ptr;
   assign rd_fire = rd && valid;
   // A read in the same cycle frees the slot the write needs.
   assign ready   = !full || rd_fire;
   assign stale   = valid && !rd;
   assign flush   = stale && (idle_cnt == TO_LAST);

   always_ff @(posedge clock)
      if (wr) mem[wr_ptr[PW-1:0]] <= wdata;

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_ptr   <= '0;
         rdata    <= '0;
         idle_cnt <= '0;
      end else begin
         if (rd_fire) rdata <= mem[rd_ptr[PW-1:0]];
         idle_cnt <= (stale && !flush) ? idle_cnt + TW'(1) : '0;
         // Flush also swallows a byte being written this cycle.
         if (flush)        rd_ptr <= wr_nx;
         else if (rd_fire) rd_ptr <= rd_ptr + (PW+1)'(1);
      end
   end

`ifdef ROUTER_1XN_DROP_BAD_EN
   logic [PW:0] cm_ptr;

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         cm_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= wr_nx;
         cm_ptr <= wr_nx;
      end else if (rollback) begin
         wr_ptr <= cm_ptr;
      end else begin
         wr_ptr <= wr_nx;
         if (commit) cm_ptr <= wr_ptr;
      end
   end

   assign vis_ptr = cm_ptr;
`else
   logic unused_ctl;
   assign unused_ctl = commit | rollback;

   always_ff @(posedge clock) begin
      if (reset) wr_ptr <= '0;
      else       wr_ptr <= wr_nx;
   end

   assign vis_ptr = wr_ptr;
`endif

endmodule

// File: rtl/router_1xn.sv
// 1-to-N byte-serial packet router: header decode, parity/length check, backpressure.
// Build with ROUTER_1XN_DROP_BAD_EN to hide failed packets from readers.
module router_1xn
   import router_1xn_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int NUM_PORTS = 3,
   parameter int DEPTH     = 16,
   parameter int TIMEOUT   = 30
) (
   input logic         clock,
   input logic         reset,
   router_1xn_if.slave bus
);
   localparam int ADDR_W = addr_w(NUM_PORTS);
   localparam int LEN_W  = len_w(DATA_W, NUM_PORTS);

   state_t                           state;
   logic [ADDR_W-1:0]                dest, hdr_addr, sel;
   logic [LEN_W-1:0]                 hdr_len, len, cnt;
   logic [DATA_W-1:0]                par;
   logic                             addr_ok, busy, error, drop, mism;
   logic [NUM_PORTS-1:0]             wr, ready, flush, valid, commit, rollback;
   logic [NUM_PORTS-1:0][DATA_W-1:0] rdata;

   assign hdr_addr = bus.data_in[HDR_ADDR_LSB +: ADDR_W];
   assign hdr_len  = bus.data_in[DATA_W-1 -: LEN_W];
   assign addr_ok  = {1'b0, hdr_addr} < (ADDR_W+1)'(NUM_PORTS);
   assign sel      = (state == IDLE) ? hdr_addr : dest;
   assign mism     = (par != bus.data_in) || (cnt != len);

   always_comb begin
      busy = 1'b0;
      wr   = '0;
      case (state)
         IDLE: if (bus.pkt_valid && addr_ok) begin
            busy    = !ready[sel];
            wr[sel] = ready[sel];
         end
         LOAD: begin
            busy    = !ready[sel];
            wr[sel] = ready[sel];
         end
         CHECK:   busy = 1'b1;
         default: ;
      endcase
   end

`ifdef ROUTER_1XN_DROP_BAD_EN
   always_comb begin
      commit   = '0;
      rollback = '0;
      if (state == CHECK) begin
         commit[dest]   = !error;
         rollback[dest] = error;
      end
   end
`else
   assign commit   = '0;
   assign rollback = '0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         dest  <= '0;
         par   <= '0;
         len   <= '0;
         cnt   <= '0;
         error <= 1'b0;
         drop  <= 1'b0;
      end else begin
         error <= 1'b0;
         drop  <= 1'b0;
         case (state)
            IDLE: if (bus.pkt_valid) begin
               if (!addr_ok) state <= DROP;
               else if (ready[hdr_addr]) begin
                  dest  <= hdr_addr;
                  par   <= bus.data_in;
                  len   <= hdr_len;
                  cnt   <= '0;
                  state <= flush[hdr_addr] ? DROP : LOAD;
               end
            end
            LOAD: if (flush[dest]) begin
               // Queue emptied under us: discard the rest of this packet.
               drop  <= ready[dest] && !bus.pkt_valid;
               state <= (ready[dest] && !bus.pkt_valid) ? IDLE : DROP;
            end else if (ready[dest]) begin
               if (bus.pkt_valid) begin
                  par <= par ^ bus.data_in;
                  cnt <= cnt + LEN_W'(1);
               end else begin
                  error <= mism;
`ifdef ROUTER_1XN_DROP_BAD_EN
                  drop  <= mism;
`endif
                  state <= CHECK;
               end
            end
            CHECK: state <= IDLE;
            DROP: if (!bus.pkt_valid) begin
               drop  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
      router_1xn_fifo #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH),
         .TIMEOUT(TIMEOUT)
      ) u_fifo (
         .clock   (clock),
         .reset   (reset),
         .wr      (wr[k]),
         .wdata   (bus.data_in),
         .rd      (bus.read_enb[k]),
         .commit  (commit[k]),
         .rollback(rollback[k]),
         .rdata   (rdata[k]),
         .valid   (valid[k]),
         .ready   (ready[k]),
         .flush   (flush[k])
      );
   end

   assign bus.data_out  = rdata;
   assign bus.valid_out = valid;
   assign bus.busy      = busy;
   assign bus.error     = error;
   assign bus.drop      = drop;

endmodule

// File: tb/tb_router_1xn.sv
// Directed bench for router_1xn (NUM_PORTS=3, DEPTH=16, TIMEOUT=30).
// Inputs change on the falling edge; outputs are read on the falling edge.
module tb_router_1xn;
   localparam int DW = 8;
   localparam int NP = 3;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   router_1xn_if #(.DATA_W(DW), .NUM_PORTS(NP)) bus ();

   router_1xn #(.DATA_W(DW), .NUM_PORTS(NP), .DEPTH(16), .TIMEOUT(30)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;
   int nbusy  = 0;
   int n0;
   logic [7:0] par;
   logic [7:0] b;
   logic [7:0] q0[$], q1[$], q2[$], exp_q[$], got[$];

   // Capture every word a reader actually pulls out.
   always @(posedge clock) begin
      logic [NP-1:0] f;
      f = bus.read_enb & bus.valid_out & {NP{~reset}};
      #1;
      if (f[0]) q0.push_back(bus.data_out[7:0]);
      if (f[1]) q1.push_back(bus.data_out[15:8]);
      if (f[2]) q2.push_back(bus.data_out[23:16]);
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish, required finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] pay(input logic [7:0] seed, input int i);
      return seed + 8'(i * 7);
   endfunction

   task automatic send(input logic [7:0] d, input logic pv);
      logic bz;
      bit   done;
      done = 0;
      bus.data_in   = d;
      bus.pkt_valid = pv;
      for (int i = 0; i < 64 && !done; i++) begin
         #1 bz = bus.busy;
         @(posedge clock);
         @(negedge clock);
         if (bz) nbusy++;
         else done = 1;
      end
      if (!done) begin
         checks++;
         errors++;
         $error("FAIL accept_timeout: observed=busy expected=accepted");
      end
      if (pv) par = par ^ d;
      exp_q.push_back(d);
   endtask

   task automatic send_pkt(input logic [7:0] hdr, input int n, input logic [7:0] seed,
                           input logic bad);
      par = 8'h00;
      send(hdr, 1'b1);
      for (int i = 0; i < n; i++) send(pay(seed, i), 1'b1);
      send(bad ? ~par : par, 1'b0);
   endtask

   task automatic wait_empty(input string tag, input int port);
      bit done;
      done = 0;
      for (int i = 0; i < 64 && !done; i++) begin
         if (!bus.valid_out[port]) done = 1;
         else @(negedge clock);
      end
      if (!done) begin
         checks++;
         errors++;
         $error("FAIL %s_drain: observed=valid_out high expected=drained", tag);
      end
   endtask

   task automatic chk_stream(input string tag, input int port);
      int mism;
      case (port)
         0:       got = q0;
         1:       got = q1;
         default: got = q2;
      endcase
      chk({tag, "_len"}, got.size(), exp_q.size());
      mism = 0;
      for (int i = 0; i < got.size() && i < exp_q.size(); i++)
         if (got[i] !== exp_q[i]) mism++;
      chk({tag, "_data"}, mism, 0);
   endtask

   initial begin
      reset         = 1'b1;
      bus.data_in   = '0;
      bus.pkt_valid = 1'b0;
      bus.read_enb  = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_data_out", bus.data_out, 0);
      chk("rst_valid_out", bus.valid_out, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_error", bus.error, 0);
      chk("rst_drop", bus.drop, 0);
      reset = 1'b0;
      @(negedge clock);

      // Good packet, port 0, len 14, reader always on.
      bus.read_enb = 3'b001;
      q0.delete(); exp_q.delete(); nbusy = 0;
      send_pkt(8'h38, 14, 8'h11, 1'b0);
      chk("t1_busy", nbusy, 0);
      chk("t1_error", bus.error, 0);
      chk("t1_valid_hold", bus.valid_out[0], 1);
      @(negedge clock);
      chk("t1_valid_fall", bus.valid_out[0], 0);
      chk_stream("t1_stream", 0);
      repeat (2) @(negedge clock);

`ifndef ROUTER_1XN_DROP_BAD_EN
      // Fill port 1 to DEPTH, then unblock with a same-cycle read.
      bus.read_enb = 3'b000;
      q1.delete(); exp_q.delete(); nbusy = 0; par = 8'h00;
      send(8'h41, 1'b1);
      for (int i = 0; i < 15; i++) send(pay(8'h20, i), 1'b1);
      chk("t2_no_early_busy", nbusy, 0);
      b = pay(8'h20, 15);
      bus.data_in   = b;
      bus.pkt_valid = 1'b1;
      #1 chk("t2_busy_full", bus.busy, 1);
      bus.read_enb = 3'b010;
      #1 chk("t2_busy_released", bus.busy, 0);
      @(posedge clock);
      @(negedge clock);
      par = par ^ b;
      exp_q.push_back(b);
      send(par, 1'b0);
      chk("t2_error", bus.error, 0);
      wait_empty("t2", 1);
      chk_stream("t2_stream", 1);
      repeat (2) @(negedge clock);
`endif

      // Bad parity to port 2.
      bus.read_enb = 3'b000;
      q2.delete(); exp_q.delete(); nbusy = 0;
      send_pkt(8'h32, 12, 8'h05, 1'b1);
      chk("t3_error_pulse", bus.error, 1);
`ifdef ROUTER_1XN_DROP_BAD_EN
      chk("t3_drop_pulse", bus.drop, 1);
`endif
      @(negedge clock);
      chk("t3_error_once", bus.error, 0);
`ifdef ROUTER_1XN_DROP_BAD_EN
      bus.read_enb = 3'b100;
      repeat (5) @(negedge clock);
      chk("t3_hidden", bus.valid_out[2], 0);
      chk("t3_none_read", q2.size(), 0);
`else
      chk("t3_visible", bus.valid_out[2], 1);
      bus.read_enb = 3'b100;
      wait_empty("t3", 2);
      chk_stream("t3_stream", 2);
`endif
      repeat (2) @(negedge clock);

      // Bad address is swallowed without backpressure.
      bus.read_enb = 3'b000;
      n0 = q0.size() + q1.size() + q2.size();
      nbusy = 0;
      send_pkt(8'h0B, 2, 8'h70, 1'b0);
      chk("t4_busy", nbusy, 0);
      chk("t4_drop_pulse", bus.drop, 1);
      chk("t4_error", bus.error, 0);
      chk("t4_fifos", bus.valid_out, 0);
      @(negedge clock);
      chk("t4_drop_once", bus.drop, 0);
      chk("t4_no_reads", q0.size() + q1.size() + q2.size(), n0);

      // Unread port 0 is flushed after TIMEOUT cycles.
      n0 = q0.size();
      send_pkt(8'h38, 14, 8'h33, 1'b0);
      repeat (14) @(negedge clock);
      chk("t5_before_timeout", bus.valid_out[0], 1);
      @(negedge clock);
      chk("t5_flushed", bus.valid_out[0], 0);
      chk("t5_no_reads", q0.size(), n0);
      bus.read_enb = 3'b001;
      q0.delete(); exp_q.delete();
      send_pkt(8'h0C, 3, 8'h44, 1'b0);
      chk("t5_after_error", bus.error, 0);
      wait_empty("t5", 0);
      chk_stream("t5_stream", 0);

      // Reset in mid-payload, then a clean packet to port 1.
      bus.read_enb = 3'b000;
      par = 8'h00;
      send(8'h29, 1'b1);
      for (int i = 0; i < 4; i++) send(pay(8'h55, i), 1'b1);
      reset         = 1'b1;
      bus.pkt_valid = 1'b0;
      @(posedge clock);
      @(negedge clock);
      chk("t6_rst_data_out", bus.data_out, 0);
      chk("t6_rst_valid_out", bus.valid_out, 0);
      chk("t6_rst_busy", bus.busy, 0);
      chk("t6_rst_error", bus.error, 0);
      chk("t6_rst_drop", bus.drop, 0);
      reset = 1'b0;
      @(negedge clock);
      bus.read_enb = 3'b010;
      q1.delete(); exp_q.delete();
      send_pkt(8'h15, 5, 8'h66, 1'b0);
      chk("t6_error", bus.error, 0);
      wait_empty("t6", 1);
      chk_stream("t6_stream", 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
